regfile_param: RTL and testbench
================================

# regfile_param

Parametrised general-purpose register file for the MIPS datapath: one write port, `NRP` asynchronous read ports, a configurable data width and depth, and an optional hard-wired zero register. Storage is cleared by a post-reset initialisation sweep rather than a simulation-only `initial` block, so the clear also happens in synthesised hardware. The stack-pointer preset is written during that sweep. The block sits between instruction decode (read addresses) and write-back (write port).

## Interface
- `DW`, 32: data width in bits.
- `DEPTH`, 32: number of registers; must be a power of two, ≥ 2.
- `AW`, $clog2(DEPTH): address width.
- `NRP`, 2: number of read ports, 1–4.
- `ZERO_REG`, 1: when 1, register 0 always reads 0 and ignores writes.
- `SP_IDX`, 29: index of the register that receives `SP_INIT` during the sweep.
- `SP_INIT`, 32'h0001_0000: reset value of register `SP_IDX`, truncated to `DW` bits.

Ports:
- `clk` input 1: clock. All state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `rd_addr` input NRP*AW: read addresses; port k uses bits [k*AW +: AW].
- `rd_data` output NRP*DW: read data; port k drives bits [k*DW +: DW].
- `wr_en` input 1: write enable.
- `wr_addr` input AW: write address.
- `wr_data` input DW: write data.
- `ready` output 1: high when initialisation is complete and the file is accepting writes.

## Operation
- FSM states:
  - `RST`: entered asynchronously whenever `rst_n`=0.
  - `INIT`: entered on the first `clk` edge after `rst_n` goes high.
  - `READY`: final state.
- `INIT` sweep:
  - Counter `init_idx` (AW bits) starts at 0.
  - Each cycle the sweep writes `SP_INIT` to entry `init_idx` when `init_idx`==`SP_IDX`, otherwise 0.
  - It then increments `init_idx`.
  - When `init_idx`==DEPTH-1, the last entry is written and the FSM moves to `READY`. The counter wraps to 0 and is not used again.
- Reset values:
  - `ready`=0 in `RST` and `INIT`, and 1 in `READY`.
  - `init_idx`=0 in `RST`.
  - `rd_data` is all zeros whenever `ready`=0, whatever the array holds.
- Writes:
  - In `READY`, when `wr_en`=1, `wr_data` is stored at `wr_addr` on the rising edge.
  - When `ZERO_REG`=1 and `wr_addr`=0, the write is discarded.
  - Writes presented while `ready`=0 are discarded; they are not queued.
- Reads:
  - Combinational: `rd_data[k]` = array[`rd_addr[k]`].
  - When `ZERO_REG`=1 and `rd_addr[k]`=0, `rd_data[k]` is forced to 0.
- Several read ports may address the same register; each returns the same value.
- Reset asserted during `INIT` or `READY`:
  - The FSM returns to `RST` and `ready` drops to 0 immediately (asynchronously).
  - A full sweep is repeated after release.
  - Array contents are undefined until that sweep completes.

## Timing
- Read latency: combinational, zero cycles.
- Write-to-read visibility without bypass: the new value is visible from the cycle after the write edge. A read of the same address in the write cycle returns the old value.
- Initialisation length: `ready` rises exactly DEPTH rising edges after `rst_n` deasserts. The first edge with `rst_n`=1 writes entry 0.
- A write in the first `READY` cycle is accepted.

## Configuration
- Macro `REGFILE_BYPASS_EN`.
- Defined: in `READY`, when `wr_en`=1 and `wr_addr`==`rd_addr[k]`, `rd_data[k]` returns `wr_data` in the same cycle. This is write-through forwarding for a read-in-same-cycle pipeline. `ZERO_REG` masking takes priority, so address 0 still reads 0.
- Not defined: no forwarding. Reads always return the array contents as described under Timing.

## Structure
- Shared package `regfile_pkg`:
  - Default constants `REGFILE_DW`, `REGFILE_DEPTH`, `REGFILE_SP_IDX`, `REGFILE_SP_INIT`.
  - State enum `regfile_state_t` {RST, INIT, READY}.
- Sub-module `regfile_init_fsm`:
  - Owns the state register and `init_idx`.
  - Outputs `ready`, `init_we`, `init_addr`, `init_data`.
- Top level:
  - Muxes the sweep write against the user write port; the sweep has priority whenever `ready`=0.
  - Holds the storage array and the read muxes.

## Test plan
- Reset release, defaults: DEPTH=32. Release `rst_n`, count edges. `ready` rises on edge 32. Reading all 32 entries then gives 0 everywhere except entry 29 = 32'h0001_0000.
- Basic write/read: write 32'hDEAD_BEEF to r5, then read r5 on port 0 and port 1 the next cycle. Both return 32'hDEAD_BEEF.
- Zero register: write 32'hFFFF_FFFF to r0. r0 reads 0 on all ports, with and without `REGFILE_BYPASS_EN`.
- Write during init: assert `wr_en` to r3 with 32'h1234 on cycle 5 of the sweep. After `ready`, r3 reads 0.
- Same-cycle read of a write address: write 32'hA5A5 to r7 while `rd_addr[0]`=7.
  - Bypass build: 32'hA5A5 in that cycle.
  - Non-bypass build: the old value in that cycle, then 32'hA5A5 in the next cycle.
- Reset mid-operation: write r10=32'h55, then pulse `rst_n` low for 1 ns between edges. `ready` drops immediately and the sweep restarts. After 32 edges r10 reads 0 and r29 reads 32'h0001_0000. Repeat with NRP=4, DW=16, DEPTH=16, SP_IDX=15; r15 reads 16'h0000 (SP_INIT truncated).

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : regfile_pkg                                                  |
// | Description : Shared constants and state encoding for the parametrised     |
// |               MIPS register file (regfile_param / regfile_init_fsm).       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package regfile_pkg;

    // Default geometry and stack-pointer preset for the MIPS integer file.
    localparam int          REGFILE_DW      = 32;
    localparam int          REGFILE_DEPTH   = 32;
    localparam int          REGFILE_SP_IDX  = 29;
    localparam logic [31:0] REGFILE_SP_INIT = 32'h0001_0000;

    // RST    : held while rst_n is low, and for the first edge after release
    // INIT   : clearing sweep in progress
    // READY  : sweep complete, user write port live
    typedef enum logic [1:0] {
        RST   = 2'd0,
        INIT  = 2'd1,
        READY = 2'd2
    } regfile_state_t;

endpackage
`default_nettype wire

// File: rtl/regfile_init_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : regfile_init_fsm                                             |
// | Description : Post-reset initialisation sequencer for the register file.  |
// |               Walks every entry once, emitting a write of zero (or of      |
// |               SP_INIT at SP_IDX), then raises ready.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk        in   1   clock, rising edge                                   |
// |   rst_n      in   1   asynchronous active-low reset                        |
// |   ready      out  1   sweep finished, file accepts user writes             |
// |   init_we    out  1   sweep write strobe (high whenever not ready)         |
// |   init_addr  out  AW  sweep write address                                  |
// |   init_data  out  DW  sweep write data                                     |
// +----------------------------------------------------------------------------+
module regfile_init_fsm
    import regfile_pkg::*;
#(
    parameter int             DW      = REGFILE_DW,
    parameter int             DEPTH   = REGFILE_DEPTH,
    parameter int             AW      = $clog2(DEPTH),
    parameter int             SP_IDX  = REGFILE_SP_IDX,
    parameter logic [DW-1:0]  SP_INIT = DW'(REGFILE_SP_INIT)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          ready,
    output logic          init_we,
    output logic [AW-1:0] init_addr,
    output logic [DW-1:0] init_data
);

    localparam logic [AW-1:0] c_last_idx = AW'(DEPTH - 1);
    localparam logic [AW-1:0] c_sp_idx   = AW'(SP_IDX);

    regfile_state_t r_state;
    regfile_state_t w_state_nxt;
    logic [AW-1:0]  r_init_idx;
    logic [AW-1:0]  w_init_idx_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RST;
            r_init_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_idx <= w_init_idx_nxt;
        end
    end

    // RST already drives the entry-0 write, so the first edge after release
    // clears entry 0 and the last entry lands on exactly the DEPTH-th edge.
    always_comb begin
        w_state_nxt    = r_state;
        w_init_idx_nxt = r_init_idx;
        case (r_state)
            RST, INIT: begin
                if (r_init_idx == c_last_idx) begin
                    w_state_nxt    = READY;
                    w_init_idx_nxt = '0;
                end else begin
                    w_state_nxt    = INIT;
                    w_init_idx_nxt = r_init_idx + AW'(1);
                end
            end
            READY: begin
                w_state_nxt = READY;
            end
            default: begin
                w_state_nxt    = RST;
                w_init_idx_nxt = '0;
            end
        endcase
    end

    assign ready     = (r_state == READY);
    assign init_we   = (r_state != READY);
    assign init_addr = r_init_idx;
    assign init_data = (r_init_idx == c_sp_idx) ? SP_INIT : '0;

endmodule
`default_nettype wire

// File: rtl/regfile_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : regfile_param                                                |
// | Description : Parametrised MIPS general-purpose register file. One write  |
// |               port, NRP combinational read ports, optional hard-wired      |
// |               zero register, hardware clearing sweep after reset.          |
// | Option      : `define REGFILE_BYPASS_EN for same-cycle write forwarding    |
// |               onto matching read ports.                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk      in   1       clock, rising edge                                 |
// |   rst_n    in   1       asynchronous active-low reset                      |
// |   rd_addr  in   NRP*AW  read addresses, port k at [k*AW +: AW]            |
// |   rd_data  out  NRP*DW  read data, port k at [k*DW +: DW]                 |
// |   wr_en    in   1       write enable                                       |
// |   wr_addr  in   AW      write address                                      |
// |   wr_data  in   DW      write data                                         |
// |   ready    out  1       initialisation done, writes accepted               |
// +----------------------------------------------------------------------------+
module regfile_param
    import regfile_pkg::*;
#(
    parameter int          DW       = REGFILE_DW,
    parameter int          DEPTH    = REGFILE_DEPTH,
    parameter int          AW       = $clog2(DEPTH),
    parameter int          NRP      = 2,
    parameter int          ZERO_REG = 1,
    parameter int          SP_IDX   = REGFILE_SP_IDX,
    parameter logic [31:0] SP_INIT  = REGFILE_SP_INIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRP*AW-1:0] rd_addr,
    output logic [NRP*DW-1:0] rd_data,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DW-1:0]     wr_data,
    output logic              ready
);

    localparam logic [DW-1:0] c_sp_init = DW'(SP_INIT);
    localparam bit            c_zero_en = (ZERO_REG != 0);

    logic          w_init_we;
    logic [AW-1:0] w_init_addr;
    logic [DW-1:0] w_init_data;

    logic          w_user_we;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [DW-1:0] w_wdata;

    logic [DW-1:0] r_mem [DEPTH];

    regfile_init_fsm #(
        .DW      (DW),
        .DEPTH   (DEPTH),
        .AW      (AW),
        .SP_IDX  (SP_IDX),
        .SP_INIT (c_sp_init)
    ) u_init_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .ready     (ready),
        .init_we   (w_init_we),
        .init_addr (w_init_addr),
        .init_data (w_init_data)
    );

    // Until ready the sweep owns the write port outright; user writes in
    // that window are simply dropped.
    assign w_user_we = wr_en && !(c_zero_en && (wr_addr == '0));
    assign w_we      = ready ? w_user_we : w_init_we;
    assign w_waddr   = ready ? wr_addr   : w_init_addr;
    assign w_wdata   = ready ? wr_data   : w_init_data;

    // Storage carries no reset: its contents are defined by the sweep.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    for (genvar k = 0; k < NRP; k++) begin : g_rd_port
        logic [AW-1:0] w_raddr;
        logic [DW-1:0] w_arr_data;
        logic [DW-1:0] w_sel_data;
        logic          w_force_zero;

        assign w_raddr    = rd_addr[k*AW +: AW];
        assign w_arr_data = r_mem[w_raddr];
`ifdef REGFILE_BYPASS_EN
        assign w_sel_data = (ready && wr_en && (wr_addr == w_raddr)) ? wr_data : w_arr_data;
`else
        assign w_sel_data = w_arr_data;
`endif
        // Zero-register masking sits after forwarding so r0 can never leak
        // a forwarded value; not-ready masks stale or uncleared contents.
        assign w_force_zero           = !ready || (c_zero_en && (w_raddr == '0));
        assign rd_data[k*DW +: DW]    = w_force_zero ? '0 : w_sel_data;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_regfile_param                                             |
// | Description : Scoreboard bench for regfile_param. Two instances: default   |
// |               32x32/2-port and 16x16/4-port with SP_IDX=15. Expected read  |
// |               data comes from an array model driven by edge counting.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_regfile_param;

    localparam logic [31:0] SP_FULL = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        a_wr_en = 1'b0;
    logic [4:0]  a_wr_addr = '0;
    logic [31:0] a_wr_data = '0;
    logic [9:0]  a_rd_addr = '0;
    logic [63:0] a_rd_data;
    logic        a_ready;

    logic        b_wr_en = 1'b0;
    logic [3:0]  b_wr_addr = '0;
    logic [15:0] b_wr_data = '0;
    logic [15:0] b_rd_addr = '0;
    logic [63:0] b_rd_data;
    logic        b_ready;

    regfile_param #(
        .DW(32), .DEPTH(32), .NRP(2), .ZERO_REG(1), .SP_IDX(29), .SP_INIT(SP_FULL)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .ready(a_ready)
    );

    regfile_param #(
        .DW(16), .DEPTH(16), .NRP(4), .ZERO_REG(1), .SP_IDX(15), .SP_INIT(SP_FULL)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .ready(b_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    // edges = rising edges seen since rst_n last released. A file is ready
    // once edges reaches its DEPTH; at that edge its image becomes
    // "all zero except SP_IDX = SP_INIT truncated".
    int          edges = 0;
    logic [31:0] mem_a [32];
    logic [15:0] mem_b [16];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edges <= 0;
        end else begin
            edges <= edges + 1;
            if (edges >= 32 && a_wr_en && a_wr_addr != 5'd0) mem_a[a_wr_addr] <= a_wr_data;
            if (edges >= 16 && b_wr_en && b_wr_addr != 4'd0) mem_b[b_wr_addr] <= b_wr_data;
            if (edges == 31) for (int i = 0; i < 32; i++) mem_a[i] <= (i == 29) ? SP_FULL : 32'h0;
            if (edges == 15) for (int i = 0; i < 16; i++) mem_b[i] <= (i == 15) ? SP_FULL[15:0] : 16'h0;
        end
    end

    function automatic logic [31:0] exp_a(input logic [4:0] ra);
        if (edges < 32) return 32'h0;
        if (ra == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (a_wr_en && a_wr_addr == ra) return a_wr_data;
`endif
        return mem_a[ra];
    endfunction

    function automatic logic [15:0] exp_b(input logic [3:0] ra);
        if (edges < 16) return 16'h0;
        if (ra == 4'd0) return 16'h0;
`ifdef REGFILE_BYPASS_EN
        if (b_wr_en && b_wr_addr == ra) return b_wr_data;
`endif
        return mem_b[ra];
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
    } item_t;

    item_t sbq[$];
    int    checks = 0;
    int    errors = 0;
    event  ev_chk;

    task automatic push(input int sel, input logic [31:0] exp);
        item_t it;
        it.cyc = cyc;
        it.sel = sel;
        it.exp = exp;
        sbq.push_back(it);
    endtask

    task automatic push_exp();
        push(0, {31'b0, (edges >= 32)});
        push(1, exp_a(a_rd_addr[4:0]));
        push(2, exp_a(a_rd_addr[9:5]));
        push(3, {31'b0, (edges >= 16)});
        for (int k = 0; k < 4; k++) push(4 + k, {16'b0, exp_b(b_rd_addr[k*4 +: 4])});
    endtask

    function automatic string sel_name(input int sel);
        case (sel)
            0:       return "a_ready";
            1:       return "a_rd0";
            2:       return "a_rd1";
            3:       return "b_ready";
            4:       return "b_rd0";
            5:       return "b_rd1";
            6:       return "b_rd2";
            default: return "b_rd3";
        endcase
    endfunction

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            0:       return {31'b0, a_ready};
            1:       return a_rd_data[31:0];
            2:       return a_rd_data[63:32];
            3:       return {31'b0, b_ready};
            default: return {16'b0, b_rd_data[(sel-4)*16 +: 16]};
        endcase
    endfunction

    initial begin : monitor
        item_t       it;
        logic [31:0] act;
        forever begin
            @(negedge clk or ev_chk);
            while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                it  = sbq.pop_front();
                act = actual(it.sel);
                checks++;
                if (act !== it.exp) begin
                    errors++;
                    $display("FAIL %s cyc=%0d actual=%08h expected=%08h",
                             sel_name(it.sel), it.cyc, act, it.exp);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
        a_wr_en   = 1'b0;
        b_wr_en   = 1'b0;
        a_rd_addr = 10'($urandom);
        b_rd_addr = 16'($urandom);
    endtask

    task automatic wr_both(input logic [4:0] addr, input logic [31:0] data);
        a_wr_en   = 1'b1;
        a_wr_addr = addr;
        a_wr_data = data;
        b_wr_en   = 1'b1;
        b_wr_addr = addr[3:0];
        b_wr_data = data[15:0];
    endtask

    initial begin : stim
        // held in reset: everything reads zero, not ready
        repeat (3) begin next_cycle(); push_exp(); end

        // release, then walk through the sweep with a write attempt mid-way
        next_cycle();
        rst_n = 1'b1;
        push_exp();
        for (int c = 1; c <= 36; c++) begin
            next_cycle();
            if (c == 5) wr_both(5'd3, 32'h0000_1234);
            push_exp();
        end

        // full image readback on every port
        for (int i = 0; i < 32; i += 2) begin
            next_cycle();
            a_rd_addr = {5'(i + 1), 5'(i)};
            b_rd_addr = {4'(i + 3), 4'(i + 2), 4'(i + 1), 4'(i)};
            push_exp();
        end

        // basic write, read same cycle then next cycle
        next_cycle();
        wr_both(5'd5, 32'hDEAD_BEEF);
        a_rd_addr = {5'd5, 5'd5};
        b_rd_addr = {4'd5, 4'd5, 4'd5, 4'd5};
        push_exp();
        next_cycle();
        a_rd_addr = {5'd5, 5'd5};
        b_rd_addr = {4'd5, 4'd5, 4'd5, 4'd5};
        push_exp();

        // zero register write
        next_cycle();
        wr_both(5'd0, 32'hFFFF_FFFF);
        a_rd_addr = '0;
        b_rd_addr = '0;
        push_exp();
        next_cycle();
        a_rd_addr = '0;
        b_rd_addr = '0;
        push_exp();

        // same-cycle read of the write address
        next_cycle();
        wr_both(5'd7, 32'h0000_A5A5);
        a_rd_addr = {5'd1, 5'd7};
        b_rd_addr = {4'd1, 4'd2, 4'd3, 4'd7};
        push_exp();
        next_cycle();
        a_rd_addr = {5'd7, 5'd7};
        b_rd_addr = {4'd7, 4'd7, 4'd7, 4'd7};
        push_exp();

        // randomized traffic, half the time aliasing a read onto the write
        repeat (200) begin
            next_cycle();
            a_wr_en   = 1'($urandom_range(0, 1));
            a_wr_addr = 5'($urandom);
            a_wr_data = $urandom;
            b_wr_en   = 1'($urandom_range(0, 1));
            b_wr_addr = 4'($urandom);
            b_wr_data = 16'($urandom);
            if ($urandom_range(0, 1) == 1) a_rd_addr[9:5] = a_wr_addr;
            if ($urandom_range(0, 1) == 1) b_rd_addr[11:8] = b_wr_addr;
            push_exp();
        end

        // reset mid-operation
        next_cycle();
        wr_both(5'd10, 32'h0000_0055);
        push_exp();
        next_cycle();
        a_rd_addr = {5'd10, 5'd10};
        b_rd_addr = {4'd10, 4'd10, 4'd10, 4'd10};
        push_exp();
        next_cycle();
        rst_n = 1'b0;
        #1;
        push_exp();
        ->ev_chk;
        #1;
        rst_n = 1'b1;
        repeat (34) begin next_cycle(); push_exp(); end
        next_cycle();
        a_rd_addr = {5'd29, 5'd10};
        b_rd_addr = {4'd15, 4'd10, 4'd15, 4'd10};
        push_exp();

        // drain
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_drain pending=%0d required=0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
